layer_ack_counter: RTL and testbench
====================================

Name: layer_ack_counter

Overview:
- Parametrised successor to the per-layer MAC acknowledge counter.
- Counts input-element acknowledges from the previous stage. After COUNT of them, it raises ack_mac to start the layer's MAC stage.
- Adds:
  - configurable count;
  - sticky or pulse output mode;
  - a downstream release handshake for back-to-back batches;
  - a batch counter and an overflow flag.
- Sits between the layer's input handshake and its MAC/accumulate logic.

Parameters:
- COUNT, 3, number of ack strobes per batch; legal range 1..2**16-1.
- CNT_W, $clog2(COUNT+1), width of the element counter; must hold COUNT.
- STICKY, 1. 1: ack_mac holds until ack_rel. 0: ack_mac is a one-cycle pulse and the block rearms itself.
- BATCH_W, 8, width of the completed-batch counter.

Ports:
- clk  in  1  single clock; all state updates on the falling edge, consistent with the layer pipeline.
- rst  in  1  synchronous, active-high reset, sampled on the active edge of clk.
- ack  in  1  one input element accepted this cycle.
- ack_rel  in  1  downstream has consumed the batch; used only when STICKY=1.
- ack_mac  out  1  batch complete; MAC may proceed.
- busy  out  1  high while at least one ack of the current batch has been counted and the batch is not yet complete.
- count  out  CNT_W  acks counted in the current batch.
- batches  out  BATCH_W  completed batches; wraps modulo 2**BATCH_W.
- overflow  out  1  sticky error: an ack arrived while the block was in DONE.

Behaviour:
- Reset. When rst=1 at an edge, the block goes to ACCUM with:
  - count=0, ack_mac=0, busy=0, batches=0, overflow=0.
  - rst has priority over every other input.
  - Reset mid-batch or in DONE discards all progress; no ack_mac is produced.
- States: ACCUM, DONE. DONE is reachable only when STICKY=1.
- ACCUM:
  - ack=1 and count<COUNT-1: count<=count+1; busy=1.
  - ack=1 and count==COUNT-1 (the COUNT-th ack): ack_mac<=1 at that same edge; batches<=batches+1.
    - STICKY=1: count<=COUNT, go to DONE.
    - STICKY=0: count<=0, stay in ACCUM; ack_mac<=0 at the next edge unless that edge again completes a batch.
  - ack=0: hold all state.
  - ack_rel is ignored in ACCUM.
- COUNT=1: every ack completes a batch. With STICKY=0, consecutive acks make ack_mac stay high, one batch per cycle.
- DONE (STICKY=1):
  - ack_mac=1 and count=COUNT are held.
  - ack_rel=1 and ack=0: ack_mac<=0, count<=0, go to ACCUM.
  - ack_rel=1 and ack=1: release wins; the ack counts as the first element of the next batch (count<=1, go to ACCUM). If COUNT=1, ack_mac stays 1, batches increments, and the block stays in DONE.
  - ack_rel=0 and ack=1: the ack is dropped; overflow<=1.
- overflow clears only on rst.
- busy: combinational, (state==ACCUM) && (count!=0).
- Widths and arithmetic:
  - count never exceeds COUNT.
  - batches increments modulo 2**BATCH_W, 255 -> 0 at default.
  - All comparisons are unsigned at width CNT_W.
- Latency: ack_mac rises at the edge that samples the COUNT-th ack (zero added latency).
- Elaboration: COUNT=0 or CNT_W too narrow to hold COUNT is an elaboration-time error.

Decomposition:
- Shared package layer_ctrl_pkg holds:
  - state enum (ST_ACCUM, ST_DONE);
  - a function computing CNT_W from COUNT, reused by other layer counters.
- No sub-module. The single FSM plus the counter fits in one module.
- Each layer instantiates one copy, with COUNT equal to its fan-in.

Test Plan:
1. STICKY=1, COUNT=3:
   - rst, then ack high for 3 edges -> count 1,2,3; ack_mac=1 at the 3rd edge; batches=1; busy=0.
   - ack_rel pulse -> ack_mac=0, count=0.
2. STICKY=1, COUNT=3, in DONE:
   - 2 extra acks without ack_rel -> overflow=1; count stays 3; batches stays 1.
   - Next, ack_rel together with ack -> count=1, ack_mac=0, state ACCUM.
3. STICKY=0, COUNT=3, continuous ack for 9 edges -> ack_mac high for exactly one cycle at edges 3, 6 and 9; batches=3; overflow=0.
4. Reset mid-batch, COUNT=3:
   - 2 acks, then rst -> count=0, busy=0.
   - 2 more acks -> ack_mac stays 0; the 3rd ack sets ack_mac.
5. COUNT=1, STICKY=0, BATCH_W=8: 256 consecutive acks -> ack_mac high on all 256 edges; batches wraps to 0.
6. rst asserted together with the completing ack -> ack_mac=0, count=0, batches=0 (reset priority).

Source files
------------

// File: rtl/layer_ctrl_pkg.sv
// Shared definitions for the per-layer control counters: FSM state encoding
// and counter width sizing.
package layer_ctrl_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  // Bits needed to hold values 0..n inclusive; equals $clog2(n+1) for n >= 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/layer_ack_counter.sv
// Counts element acknowledges per batch and raises ack_mac once COUNT have
// arrived; sticky (held until ack_rel) or self-rearming pulse mode.
module layer_ack_counter
  import layer_ctrl_pkg::*;
#(
  parameter int unsigned COUNT   = 3,
  parameter int unsigned CNT_W   = cnt_width(COUNT),
  parameter bit          STICKY  = 1'b1,
  parameter int unsigned BATCH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ack,
  input  logic               ack_rel,
  output logic               ack_mac,
  output logic               busy,
  output logic [CNT_W-1:0]   count,
  output logic [BATCH_W-1:0] batches,
  output logic               overflow
);

  if (COUNT == 0 || COUNT > 65535 || (COUNT >> CNT_W) != 0) begin : g_bad_count
    $error("layer_ack_counter: COUNT out of range or CNT_W too narrow");
  end

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BATCH_W-1:0] batches_q, batches_d;
  logic               mac_q, mac_d;
  logic               ovf_q, ovf_d;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= ST_ACCUM;
      count_q   <= '0;
      batches_q <= '0;
      mac_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      batches_q <= batches_d;
      mac_q     <= mac_d;
      ovf_q     <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    batches_d = batches_q;
    mac_d     = mac_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      ST_ACCUM: begin
        // In pulse mode ack_mac drops unless this edge completes another batch.
        mac_d = 1'b0;
        if (ack) begin
          if (count_q == CNT_LAST) begin
            mac_d     = 1'b1;
            batches_d = batches_q + BATCH_W'(1);
            if (STICKY) begin
              count_d = CNT_FULL;
              state_d = ST_DONE;
            end else begin
              count_d = '0;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (ack_rel) begin
          if (!ack) begin
            mac_d   = 1'b0;
            count_d = '0;
            state_d = ST_ACCUM;
          end else if (COUNT == 1) begin
            // Released and immediately refilled by a single-element batch.
            batches_d = batches_q + BATCH_W'(1);
          end else begin
            mac_d   = 1'b0;
            count_d = CNT_W'(1);
            state_d = ST_ACCUM;
          end
        end else if (ack) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign ack_mac  = mac_q;
  assign busy     = (state_q == ST_ACCUM) && (count_q != '0);
  assign count    = count_q;
  assign batches  = batches_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_layer_ack_counter.sv
// Bench for layer_ack_counter: three configurations checked against a
// reference model through a scoreboard, plus scenario-level checks.
module tb_layer_ack_counter;

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        mac;
    logic        busy;
    logic [7:0]  bat;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst = '0;
  logic [2:0] ack = '0;
  logic [2:0] rel = '0;

  logic [2:0] mac, busy, ovf;
  logic [1:0] cnt0, cnt1;
  logic [0:0] cnt2;
  logic [7:0] bat [3];

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  int   P_COUNT  [3] = '{3, 3, 1};
  bit   P_STICKY [3] = '{1'b1, 1'b0, 1'b0};
  int   m_cnt  [3];
  bit   m_mac  [3];
  int   m_bat  [3];
  bit   m_ovf  [3];
  bit   m_done [3];

  layer_ack_counter #(.COUNT(3), .STICKY(1'b1), .BATCH_W(8)) dut0 (
    .clk(clk), .rst(rst[0]), .ack(ack[0]), .ack_rel(rel[0]), .ack_mac(mac[0]),
    .busy(busy[0]), .count(cnt0), .batches(bat[0]), .overflow(ovf[0]));

  layer_ack_counter #(.COUNT(3), .STICKY(1'b0), .BATCH_W(8)) dut1 (
    .clk(clk), .rst(rst[1]), .ack(ack[1]), .ack_rel(rel[1]), .ack_mac(mac[1]),
    .busy(busy[1]), .count(cnt1), .batches(bat[1]), .overflow(ovf[1]));

  layer_ack_counter #(.COUNT(1), .STICKY(1'b0), .BATCH_W(8)) dut2 (
    .clk(clk), .rst(rst[2]), .ack(ack[2]), .ack_rel(rel[2]), .ack_mac(mac[2]),
    .busy(busy[2]), .count(cnt2), .batches(bat[2]), .overflow(ovf[2]));

  function automatic logic [15:0] obs_cnt(input int i);
    if (i == 0) return {14'b0, cnt0};
    if (i == 1) return {14'b0, cnt1};
    return {15'b0, cnt2};
  endfunction

  task automatic model_step(input int i, input logic r, input logic a, input logic l);
    if (r) begin
      m_cnt[i] = 0; m_mac[i] = 0; m_bat[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
    end else if (m_done[i]) begin
      if (l && !a) begin
        m_cnt[i] = 0; m_mac[i] = 0; m_done[i] = 0;
      end else if (l && a && P_COUNT[i] == 1) begin
        m_bat[i] = (m_bat[i] + 1) % 256;
      end else if (l && a) begin
        m_cnt[i] = 1; m_mac[i] = 0; m_done[i] = 0;
      end else if (a) begin
        m_ovf[i] = 1;
      end
    end else if (a && m_cnt[i] + 1 == P_COUNT[i]) begin
      m_mac[i] = 1;
      m_bat[i] = (m_bat[i] + 1) % 256;
      m_cnt[i] = P_STICKY[i] ? P_COUNT[i] : 0;
      m_done[i] = P_STICKY[i];
    end else begin
      m_mac[i] = 0;
      if (a) m_cnt[i] = m_cnt[i] + 1;
    end
  endtask

  // Drive one clock of stimulus to all three DUTs and queue expected outputs.
  task automatic cycle(input logic [2:0] r, input logic [2:0] a, input logic [2:0] l);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ack = a; rel = l;
    for (int i = 0; i < 3; i++) begin
      model_step(i, r[i], a[i], l[i]);
      e.id   = i;
      e.cnt  = 16'(m_cnt[i]);
      e.mac  = m_mac[i];
      e.busy = !m_done[i] && (m_cnt[i] != 0);
      e.bat  = 8'(m_bat[i]);
      e.ovf  = m_ovf[i];
      sb.push_back(e);
    end
    @(negedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (obs_cnt(e.id) !== e.cnt) begin
        bad++; $display("FAIL sb_count[%0d] got=%0d exp=%0d", e.id, obs_cnt(e.id), e.cnt);
      end
      total++;
      if (mac[e.id] !== e.mac) begin
        bad++; $display("FAIL sb_ack_mac[%0d] got=%b exp=%b", e.id, mac[e.id], e.mac);
      end
      total++;
      if (busy[e.id] !== e.busy) begin
        bad++; $display("FAIL sb_busy[%0d] got=%b exp=%b", e.id, busy[e.id], e.busy);
      end
      total++;
      if (bat[e.id] !== e.bat) begin
        bad++; $display("FAIL sb_batches[%0d] got=%0d exp=%0d", e.id, bat[e.id], e.bat);
      end
      total++;
      if (ovf[e.id] !== e.ovf) begin
        bad++; $display("FAIL sb_overflow[%0d] got=%b exp=%b", e.id, ovf[e.id], e.ovf);
      end
    end
  end

  task automatic test_reset();
    cycle(3'b111, 3'b000, 3'b000);
    total++;
    if ({mac, busy, ovf} !== 9'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0", {mac, busy, ovf});
    end
  endtask

  task automatic test_sticky();
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    total++;
    if ({mac[0], busy[0], cnt0, bat[0]} !== {1'b1, 1'b0, 2'd3, 8'd1}) begin
      bad++; $display("FAIL sticky_done got mac=%b busy=%b cnt=%0d bat=%0d exp 1 0 3 1",
                      mac[0], busy[0], cnt0, bat[0]);
    end
    cycle(3'b000, 3'b000, 3'b001);
    total++;
    if ({mac[0], cnt0} !== 3'b000) begin
      bad++; $display("FAIL sticky_release got mac=%b cnt=%0d exp 0 0", mac[0], cnt0);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) cycle(3'b000, 3'b001, 3'b000);
    for (int k = 0; k < 2; k++) cycle(3'b000, 3'b001, 3'b000);
    total++;
    if ({ovf[0], cnt0, bat[0]} !== {1'b1, 2'd3, 8'd2}) begin
      bad++; $display("FAIL overflow got ovf=%b cnt=%0d bat=%0d exp 1 3 2", ovf[0], cnt0, bat[0]);
    end
    cycle(3'b000, 3'b001, 3'b001);
    total++;
    if ({cnt0, mac[0], busy[0]} !== {2'd1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL release_with_ack got cnt=%0d mac=%b busy=%b exp 1 0 1",
                      cnt0, mac[0], busy[0]);
    end
  endtask

  task automatic test_pulse();
    int highs;
    highs = 0;
    cycle(3'b010, 3'b000, 3'b000);
    for (int k = 1; k <= 9; k++) begin
      cycle(3'b000, 3'b010, 3'b000);
      total++;
      if (mac[1] !== ((k % 3) == 0)) begin
        bad++; $display("FAIL pulse_edge%0d got=%b exp=%b", k, mac[1], (k % 3) == 0);
      end
      if (mac[1] === 1'b1) highs++;
    end
    cycle(3'b000, 3'b000, 3'b000);
    total++;
    if ({mac[1], bat[1], ovf[1]} !== {1'b0, 8'd3, 1'b0} || highs != 3) begin
      bad++; $display("FAIL pulse_summary got mac=%b bat=%0d ovf=%b highs=%0d exp 0 3 0 3",
                      mac[1], bat[1], ovf[1], highs);
    end
  endtask

  task automatic test_reset_mid();
    cycle(3'b001, 3'b000, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b001, 3'b000, 3'b000);
    total++;
    if ({cnt0, busy[0]} !== 3'b000) begin
      bad++; $display("FAIL reset_mid got cnt=%0d busy=%b exp 0 0", cnt0, busy[0]);
    end
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    total++;
    if (mac[0] !== 1'b0) begin
      bad++; $display("FAIL reset_mid_early got=%b exp=0", mac[0]);
    end
    cycle(3'b000, 3'b001, 3'b000);
    total++;
    if (mac[0] !== 1'b1) begin
      bad++; $display("FAIL reset_mid_complete got=%b exp=1", mac[0]);
    end
    cycle(3'b000, 3'b000, 3'b001);
  endtask

  task automatic test_count1();
    int highs;
    highs = 0;
    cycle(3'b100, 3'b000, 3'b000);
    for (int k = 1; k <= 256; k++) begin
      cycle(3'b000, 3'b100, 3'b000);
      if (mac[2] === 1'b1) highs++;
      if (k == 255) begin
        total++;
        if (bat[2] !== 8'd255) begin
          bad++; $display("FAIL count1_bat255 got=%0d exp=255", bat[2]);
        end
      end
    end
    total++;
    if (highs != 256 || bat[2] !== 8'd0) begin
      bad++; $display("FAIL count1_wrap got highs=%0d bat=%0d exp 256 0", highs, bat[2]);
    end
  endtask

  task automatic test_reset_priority();
    cycle(3'b001, 3'b000, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b000, 3'b001, 3'b000);
    cycle(3'b001, 3'b001, 3'b000);
    total++;
    if ({mac[0], cnt0, bat[0]} !== 11'b0) begin
      bad++; $display("FAIL reset_priority got mac=%b cnt=%0d bat=%0d exp 0 0 0",
                      mac[0], cnt0, bat[0]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sticky();
    test_overflow();
    test_pulse();
    test_reset_mid();
    test_count1();
    test_reset_priority();
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
